mult_issue_queue: RTL and testbench
===================================

# mult_issue_queue

Out-of-order issue queue feeding the pipelined integer multiplier. It holds dispatched multiply instructions, wakes their source operands from the common data bus (CDB), and selects the oldest ready entry. That entry's operands and destination tag drive the multiplier issue interface (`issuemult_*`). It also carries the destination tag alongside the multiplier pipeline, so the result stage knows which physical tag completes on which cycle.

## Interface

Parameters:
- `DEPTH`, default 4: number of queue entries, 2..8.
- `MULT_LATENCY`, default 4: cycles from `issuemult_enable` to valid product, 1..8.

Ports:
- `clk` input 1: single clock; everything is rising-edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `dispatch_enable` input 1: write one instruction this cycle.
- `dispatch_rsdata` input 32: rs value, meaningful when `dispatch_rsvalid`=1.
- `dispatch_rsvalid` input 1: rs value already available.
- `dispatch_rstag` input 6: rs producer tag when not valid.
- `dispatch_rtdata` input 32: rt value, meaningful when `dispatch_rtvalid`=1.
- `dispatch_rtvalid` input 1: rt value already available.
- `dispatch_rttag` input 6: rt producer tag when not valid.
- `dispatch_rdtag` input 6: destination tag.
- `issuequeue_full` output 1: count == `DEPTH`.
- `cdb_valid` input 1: CDB broadcast valid.
- `cdb_tag` input 6: CDB broadcast tag.
- `cdb_data` input 32: CDB broadcast value.
- `issuemult_enable` output 1: issue valid this cycle.
- `issuemult_rsdata` output 32: multiplicand.
- `issuemult_rtdata` output 32: multiplier.
- `issuemult_rdtag` output 6: destination tag of the issued op.
- `multdone_valid` output 1: product for `multdone_tag` is valid this cycle.
- `multdone_tag` output 6: tag completing this cycle.

## Operation

- Storage is a compacting FIFO-ordered array, with index 0 as the oldest entry. Each entry holds valid, rsready, rtready, rs/rt data, rs/rt tags, and rdtag.
- Dispatch is accepted when `dispatch_enable`=1 and `issuequeue_full`=0 at cycle start. It writes to index `count`, after compaction for any issue in the same cycle. Dispatch while full is silently dropped; the dispatcher must not dispatch while full.
- Dispatch bypass is always present. If `cdb_valid` and `cdb_tag` matches a not-valid dispatch operand tag in the same cycle, the operand is captured from `cdb_data` and marked ready.
- Wakeup: every valid, not-ready operand whose tag equals `cdb_tag` while `cdb_valid`=1 latches `cdb_data` and sets ready at the clock edge.
- Select: the lowest-index entry with valid, rsready and rtready is chosen. At most one issue per cycle. The selected entry is removed and higher entries shift down by one.
- Issue outputs are registered. When nothing is selected, `issuemult_enable`=0 and the data/tag outputs hold their last values.
- Completion tracker: a `MULT_LATENCY`-deep shift register of {valid, tag} is loaded from the issue outputs. `multdone_valid`/`multdone_tag` equal `issuemult_enable`/`issuemult_rdtag` delayed by exactly `MULT_LATENCY` cycles. The multiplier cannot stall.
- Tags are opaque 6-bit values; no arithmetic is done on them. Data is passed unmodified; the multiplier forms the 32-bit product.

## Timing

- Reset values:
  - all entry valid bits 0, count 0, `issuequeue_full`=0;
  - `issuemult_enable`=0, `issuemult_rsdata`=0, `issuemult_rtdata`=0, `issuemult_rdtag`=0;
  - `multdone_valid`=0, `multdone_tag`=0, shift register cleared.
- Dispatch with both operands ready in cycle D: `issuemult_enable`=1 in cycle D+2.
- CDB wakeup of the last operand in cycle W: `issuemult_enable`=1 in cycle W+2; W+1 when `MULTQ_FWD_SELECT_EN` is defined.
- `issuemult_enable` at cycle I: `multdone_valid`=1 at cycle I+`MULT_LATENCY`.
- Dispatch and issue in the same cycle: count is unchanged and the new entry lands at index count-1.
- Full in cycle N with an issue in N: `issuequeue_full` deasserts in N+1. The dispatch in N is still dropped.
- Reset asserted mid-operation discards all entries and in-flight completions. No `multdone_valid` is produced for ops issued before reset.

## Configuration

- `MULTQ_FWD_SELECT_EN` defined: select considers an operand ready if it is stored ready or matches the current CDB broadcast. The operand value is muxed from `cdb_data` into the issue register, saving one cycle on wakeup-to-issue.
- `MULTQ_FWD_SELECT_EN` undefined: select uses only stored ready bits. CDB data enters the issue path one cycle later. The ordering and oldest-first selection rules are identical in both builds.

## Structure

- Shared package/header `cobalt_defs`:
  - constants `TAG_W`=6 and `DATA_W`=32;
  - the issue-queue entry record typedef (valid, rsready, rtready, rsdata, rtdata, rstag, rttag, rdtag).
- Sub-module `mult_issue_select`: a combinational oldest-ready priority picker over `DEPTH` ready bits. It returns a one-hot grant and a found flag. The queue instantiates it once.

## Test plan

- Reset, then dispatch rs=3 and rt=5, both valid, rdtag=0x11 at cycle 0 → `issuemult_enable`=1, rsdata=3, rtdata=5, rdtag=0x11 at cycle 2. `multdone_valid`=1 with tag 0x11 at cycle 2+`MULT_LATENCY`.
- Dispatch rs pending on tag 0x07, rt=2 valid. CDB broadcasts tag 0x07, data 9 at cycle 4 → issue with rsdata=9 at cycle 6, or cycle 5 with `MULTQ_FWD_SELECT_EN`.
- Dispatch rs pending on tag 0x0A in the same cycle the CDB broadcasts 0x0A/data 7 → operand captured; issue 2 cycles later with rsdata=7.
- Fill 4 entries, all waiting → `issuequeue_full`=1, and a fifth dispatch is dropped. Wake entries 2 and 0 in the same cycle → entry 0 issues first, entry 2 next cycle, and full deasserts.
- Issue ops back-to-back on 3 consecutive cycles → `multdone_valid` is high for 3 consecutive cycles with tags in issue order.
- Assert reset with 2 entries queued and 2 ops in flight → all outputs return to 0 immediately. No `multdone_valid` occurs afterwards until new dispatches.

Source files
------------

// File: rtl/cobalt_defs.sv
// Shared definitions for the multiply issue path.
// Provides the tag/data widths, the issue-queue entry record and a CDB
// tag-match helper used by both dispatch bypass and in-queue wakeup.
package cobalt_defs;

    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;

    // One issue-queue slot: occupancy, per-operand readiness, values and tags.
    typedef struct packed {
        logic              valid;
        logic              rsready;
        logic              rtready;
        logic [DATA_W-1:0] rsdata;
        logic [DATA_W-1:0] rtdata;
        logic [TAG_W-1:0]  rstag;
        logic [TAG_W-1:0]  rttag;
        logic [TAG_W-1:0]  rdtag;
    } iq_entry_t;

    // True when a live CDB broadcast carries the tag an operand is waiting on.
    function automatic logic cdb_hit(input logic             bus_valid,
                                     input logic [TAG_W-1:0] bus_tag,
                                     input logic [TAG_W-1:0] wait_tag);
        return bus_valid && (bus_tag == wait_tag);
    endfunction

endpackage

// File: rtl/mult_issue_select.sv
// Oldest-ready picker for the multiply issue queue.
// Ports:
//   ready_i    - per-entry ready bits, index 0 is the oldest entry
//   grant_c_o  - one-hot grant of the lowest-index ready entry (combinational)
//   found_c_o  - at least one entry is ready (combinational)
module mult_issue_select #(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0] ready_i,
    output logic [DEPTH-1:0] grant_c_o,
    output logic             found_c_o
);

    // Priority scan from the oldest slot upward.
    always_comb begin
        logic hit;
        hit       = 1'b0;
        grant_c_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_i[i] && !hit) begin
                grant_c_o[i] = 1'b1;
                hit          = 1'b1;
            end
        end
        found_c_o = hit;
    end

endmodule

// File: rtl/mult_issue_queue.sv
// Out-of-order issue queue for the pipelined integer multiplier.
// Holds dispatched multiplies in a compacting oldest-first array, wakes
// operands from the CDB, issues the oldest ready entry through registered
// issuemult_* outputs and tracks the destination tag down the multiplier
// pipeline so multdone_* reports completion MULT_LATENCY cycles after issue.
// Build option: define MULTQ_FWD_SELECT_EN to let select see the current CDB
// broadcast directly (one cycle earlier wakeup-to-issue).
// Ports:
//   clk, reset (async, active-low)
//   dispatch_*        - one instruction write per cycle, dropped when full
//   issuequeue_full   - queue holds DEPTH entries
//   cdb_valid/tag/data- result broadcast used for wakeup and dispatch bypass
//   issuemult_*       - registered issue to the multiplier
//   multdone_valid/tag- completion of the op issued MULT_LATENCY cycles ago
module mult_issue_queue
    import cobalt_defs::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MULT_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_enable,
    input  logic [DATA_W-1:0] dispatch_rsdata,
    input  logic              dispatch_rsvalid,
    input  logic [TAG_W-1:0]  dispatch_rstag,
    input  logic [DATA_W-1:0] dispatch_rtdata,
    input  logic              dispatch_rtvalid,
    input  logic [TAG_W-1:0]  dispatch_rttag,
    input  logic [TAG_W-1:0]  dispatch_rdtag,
    output logic              issuequeue_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issuemult_enable,
    output logic [DATA_W-1:0] issuemult_rsdata,
    output logic [DATA_W-1:0] issuemult_rtdata,
    output logic [TAG_W-1:0]  issuemult_rdtag,
    output logic              multdone_valid,
    output logic [TAG_W-1:0]  multdone_tag
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    iq_entry_t          ent_q [DEPTH];
    iq_entry_t          ent_d [DEPTH];
    iq_entry_t          woke  [DEPTH];
    iq_entry_t          new_ent;
    iq_entry_t          sel;
    logic [CNT_W-1:0]   count_q, count_d, wr_idx;
    logic               full_q, full_d;
    logic               accept;
    logic [DEPTH-1:0]   rs_hit, rt_hit, ready, grant;
    logic               found;

    logic               iss_en_q, iss_en_d;
    logic [DATA_W-1:0]  iss_rs_q, iss_rs_d;
    logic [DATA_W-1:0]  iss_rt_q, iss_rt_d;
    logic [TAG_W-1:0]   iss_tag_q, iss_tag_d;

    logic [MULT_LATENCY-1:0] done_v_q;
    logic [TAG_W-1:0]        done_tag_q [MULT_LATENCY];

    // Per-entry CDB match on operands still waiting, and select readiness.
    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        ready  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rs_hit[i] = ent_q[i].valid && !ent_q[i].rsready &&
                        cdb_hit(cdb_valid, cdb_tag, ent_q[i].rstag);
            rt_hit[i] = ent_q[i].valid && !ent_q[i].rtready &&
                        cdb_hit(cdb_valid, cdb_tag, ent_q[i].rttag);
`ifdef MULTQ_FWD_SELECT_EN
            ready[i]  = ent_q[i].valid &&
                        (ent_q[i].rsready || rs_hit[i]) &&
                        (ent_q[i].rtready || rt_hit[i]);
`else
            ready[i]  = ent_q[i].valid && ent_q[i].rsready && ent_q[i].rtready;
`endif
        end
    end

    mult_issue_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .ready_i   (ready),
        .grant_c_o (grant),
        .found_c_o (found)
    );

    // Issue register next state; data holds when nothing is selected.
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel = ent_q[i];
            end
        end
        iss_en_d  = found;
        iss_rs_d  = iss_rs_q;
        iss_rt_d  = iss_rt_q;
        iss_tag_d = iss_tag_q;
        if (found) begin
`ifdef MULTQ_FWD_SELECT_EN
            // A selected operand that is not stored ready was woken by this broadcast.
            iss_rs_d = sel.rsready ? sel.rsdata : cdb_data;
            iss_rt_d = sel.rtready ? sel.rtdata : cdb_data;
`else
            iss_rs_d = sel.rsdata;
            iss_rt_d = sel.rtdata;
`endif
            iss_tag_d = sel.rdtag;
        end
    end

    // Incoming entry with same-cycle CDB bypass on waiting operands.
    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.rstag   = dispatch_rstag;
        new_ent.rttag   = dispatch_rttag;
        new_ent.rdtag   = dispatch_rdtag;
        new_ent.rsready = 1'b1;
        new_ent.rtready = 1'b1;
        if (dispatch_rsvalid) begin
            new_ent.rsdata = dispatch_rsdata;
        end else if (cdb_hit(cdb_valid, cdb_tag, dispatch_rstag)) begin
            new_ent.rsdata = cdb_data;
        end else begin
            new_ent.rsready = 1'b0;
        end
        if (dispatch_rtvalid) begin
            new_ent.rtdata = dispatch_rtdata;
        end else if (cdb_hit(cdb_valid, cdb_tag, dispatch_rttag)) begin
            new_ent.rtdata = cdb_data;
        end else begin
            new_ent.rtready = 1'b0;
        end
    end

    // Wakeup, compaction past the issued slot, then dispatch at the new tail.
    always_comb begin
        logic shift;
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (rs_hit[i]) begin
                woke[i].rsready = 1'b1;
                woke[i].rsdata  = cdb_data;
            end
            if (rt_hit[i]) begin
                woke[i].rtready = 1'b1;
                woke[i].rtdata  = cdb_data;
            end
        end

        shift = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift    = shift | grant[i];
            ent_d[i] = shift ? woke[i + 1] : woke[i];
        end
        ent_d[DEPTH-1] = (shift | grant[DEPTH-1]) ? '0 : woke[DEPTH-1];

        accept = dispatch_enable && !full_q;
        wr_idx = count_q - CNT_W'(found);
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (wr_idx == CNT_W'(i))) begin
                ent_d[i] = new_ent;
            end
        end

        count_d = count_q + CNT_W'(accept) - CNT_W'(found);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Queue, issue and completion-tracker state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q   <= '0;
            full_q    <= 1'b0;
            iss_en_q  <= 1'b0;
            iss_rs_q  <= '0;
            iss_rt_q  <= '0;
            iss_tag_q <= '0;
            done_v_q  <= '0;
            for (int i = 0; i < MULT_LATENCY; i++) begin
                done_tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q       <= count_d;
            full_q        <= full_d;
            iss_en_q      <= iss_en_d;
            iss_rs_q      <= iss_rs_d;
            iss_rt_q      <= iss_rt_d;
            iss_tag_q     <= iss_tag_d;
            done_v_q[0]   <= iss_en_q;
            done_tag_q[0] <= iss_tag_q;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                done_v_q[i]   <= done_v_q[i-1];
                done_tag_q[i] <= done_tag_q[i-1];
            end
        end
    end

    assign issuequeue_full  = full_q;
    assign issuemult_enable = iss_en_q;
    assign issuemult_rsdata = iss_rs_q;
    assign issuemult_rtdata = iss_rt_q;
    assign issuemult_rdtag  = iss_tag_q;
    assign multdone_valid   = done_v_q[MULT_LATENCY-1];
    assign multdone_tag     = done_tag_q[MULT_LATENCY-1];

endmodule

// File: tb/tb_mult_issue_queue.sv
// Directed bench for mult_issue_queue with an issue/completion scoreboard.
module tb_mult_issue_queue;

    localparam int DEPTH = 4;
    localparam int L     = 4;
`ifdef MULTQ_FWD_SELECT_EN
    localparam int WL = 1;
`else
    localparam int WL = 2;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  tag;
    } iss_t;

    typedef struct {
        int         cyc;
        logic [5:0] tag;
    } done_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dispatch_enable = 1'b0;
    logic [31:0] dispatch_rsdata = '0;
    logic        dispatch_rsvalid = 1'b0;
    logic [5:0]  dispatch_rstag = '0;
    logic [31:0] dispatch_rtdata = '0;
    logic        dispatch_rtvalid = 1'b0;
    logic [5:0]  dispatch_rttag = '0;
    logic [5:0]  dispatch_rdtag = '0;
    logic        issuequeue_full;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        issuemult_enable;
    logic [31:0] issuemult_rsdata;
    logic [31:0] issuemult_rtdata;
    logic [5:0]  issuemult_rdtag;
    logic        multdone_valid;
    logic [5:0]  multdone_tag;

    int    passed = 0;
    int    checks = 0;
    int    cyc = 0;
    int    w;
    int    exp_full;
    iss_t  exp_iss[$];
    done_t exp_done[$];

    mult_issue_queue #(
        .DEPTH        (DEPTH),
        .MULT_LATENCY (L)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .dispatch_enable  (dispatch_enable),
        .dispatch_rsdata  (dispatch_rsdata),
        .dispatch_rsvalid (dispatch_rsvalid),
        .dispatch_rstag   (dispatch_rstag),
        .dispatch_rtdata  (dispatch_rtdata),
        .dispatch_rtvalid (dispatch_rtvalid),
        .dispatch_rttag   (dispatch_rttag),
        .dispatch_rdtag   (dispatch_rdtag),
        .issuequeue_full  (issuequeue_full),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data),
        .issuemult_enable (issuemult_enable),
        .issuemult_rsdata (issuemult_rsdata),
        .issuemult_rtdata (issuemult_rtdata),
        .issuemult_rdtag  (issuemult_rdtag),
        .multdone_valid   (multdone_valid),
        .multdone_tag     (multdone_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic push_iss(input int c, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [5:0] tag);
        iss_t e;
        e.cyc = c; e.rs = rs; e.rt = rt; e.tag = tag;
        exp_iss.push_back(e);
    endtask

    task automatic dispatch(input logic rsv, input logic [31:0] rsd, input logic [5:0] rst,
                            input logic rtv, input logic [31:0] rtd, input logic [5:0] rtt,
                            input logic [5:0] rd);
        dispatch_enable  = 1'b1;
        dispatch_rsvalid = rsv; dispatch_rsdata = rsd; dispatch_rstag = rst;
        dispatch_rtvalid = rtv; dispatch_rtdata = rtd; dispatch_rttag = rtt;
        dispatch_rdtag   = rd;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
    endtask

    // Mid-cycle scoreboard check, then advance one cycle and drop one-shot inputs.
    task automatic tick();
        iss_t  e;
        done_t d;
        @(negedge clk);
        if (reset) begin
            if (exp_iss.size() != 0 && exp_iss[0].cyc == cyc) begin
                e = exp_iss.pop_front();
                chk("issue_en", 32'(issuemult_enable), 1);
                chk("issue_rs", issuemult_rsdata, e.rs);
                chk("issue_rt", issuemult_rtdata, e.rt);
                chk("issue_tag", 32'(issuemult_rdtag), 32'(e.tag));
                d.cyc = cyc + L; d.tag = e.tag;
                exp_done.push_back(d);
            end else begin
                chk("issue_idle", 32'(issuemult_enable), 0);
            end
            if (exp_done.size() != 0 && exp_done[0].cyc == cyc) begin
                d = exp_done.pop_front();
                chk("done_valid", 32'(multdone_valid), 1);
                chk("done_tag", 32'(multdone_tag), 32'(d.tag));
            end else begin
                chk("done_idle", 32'(multdone_valid), 0);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        dispatch_enable = 1'b0;
        cdb_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string pfx);
        chk({pfx, "_full"}, 32'(issuequeue_full), 0);
        chk({pfx, "_en"}, 32'(issuemult_enable), 0);
        chk({pfx, "_rs"}, issuemult_rsdata, 0);
        chk({pfx, "_rt"}, issuemult_rtdata, 0);
        chk({pfx, "_rdtag"}, 32'(issuemult_rdtag), 0);
        chk({pfx, "_dvalid"}, 32'(multdone_valid), 0);
        chk({pfx, "_dtag"}, 32'(multdone_tag), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("rst");
        reset = 1'b1;
        cyc = 0;

        // Both operands ready: issue two cycles later, done L after that
        dispatch(1'b1, 32'd3, 6'h00, 1'b1, 32'd5, 6'h00, 6'h11);
        push_iss(cyc + 2, 32'd3, 32'd5, 6'h11);
        tick();
        repeat (L + 3) tick();

        // rs waits on tag 0x07, woken by CDB later
        dispatch(1'b0, 32'd0, 6'h07, 1'b1, 32'd2, 6'h00, 6'h12);
        tick();
        tick();
        cdb(6'h07, 32'd9);
        push_iss(cyc + WL, 32'd9, 32'd2, 6'h12);
        tick();
        repeat (L + 3) tick();

        // Dispatch bypass: CDB matches the waiting tag in the dispatch cycle
        dispatch(1'b0, 32'd0, 6'h0A, 1'b1, 32'd4, 6'h00, 6'h13);
        cdb(6'h0A, 32'd7);
        push_iss(cyc + 2, 32'd7, 32'd4, 6'h13);
        tick();
        repeat (L + 3) tick();

        // Fill the queue with waiting ops, drop a fifth, wake entries 0 and 2 together
        chk("full_empty", 32'(issuequeue_full), 0);
        dispatch(1'b0, 32'd0, 6'h20, 1'b1, 32'd1, 6'h00, 6'h21); tick();
        dispatch(1'b0, 32'd0, 6'h30, 1'b1, 32'd2, 6'h00, 6'h22); tick();
        dispatch(1'b0, 32'd0, 6'h20, 1'b1, 32'd3, 6'h00, 6'h23); tick();
        dispatch(1'b0, 32'd0, 6'h30, 1'b1, 32'd4, 6'h00, 6'h24); tick();
        chk("full_set", 32'(issuequeue_full), 1);
        dispatch(1'b1, 32'd1, 6'h00, 1'b1, 32'd1, 6'h00, 6'h3F);
        tick();
        chk("full_hold", 32'(issuequeue_full), 1);
        w = cyc;
        cdb(6'h20, 32'd100);
        push_iss(w + WL, 32'd100, 32'd1, 6'h21);
        push_iss(w + WL + 1, 32'd100, 32'd3, 6'h23);
        tick();
        exp_full = (WL == 2) ? 1 : 0;
        chk("full_w1", 32'(issuequeue_full), 32'(exp_full));
        tick();
        chk("full_w2", 32'(issuequeue_full), 0);
        tick();
        tick();
        cdb(6'h30, 32'd200);
        push_iss(cyc + WL, 32'd200, 32'd2, 6'h22);
        push_iss(cyc + WL + 1, 32'd200, 32'd4, 6'h24);
        tick();
        repeat (L + 4) tick();
        chk("full_drained", 32'(issuequeue_full), 0);

        // Back-to-back issues and completions
        dispatch(1'b1, 32'd10, 6'h00, 1'b1, 32'd11, 6'h00, 6'h31);
        push_iss(cyc + 2, 32'd10, 32'd11, 6'h31);
        tick();
        dispatch(1'b1, 32'd12, 6'h00, 1'b1, 32'd13, 6'h00, 6'h32);
        push_iss(cyc + 2, 32'd12, 32'd13, 6'h32);
        tick();
        dispatch(1'b1, 32'd14, 6'h00, 1'b1, 32'd15, 6'h00, 6'h33);
        push_iss(cyc + 2, 32'd14, 32'd15, 6'h33);
        tick();
        repeat (L + 4) tick();

        // Reset with two ops in flight and two entries queued
        dispatch(1'b1, 32'd6, 6'h00, 1'b1, 32'd7, 6'h00, 6'h34);
        push_iss(cyc + 2, 32'd6, 32'd7, 6'h34);
        tick();
        dispatch(1'b1, 32'd8, 6'h00, 1'b1, 32'd9, 6'h00, 6'h35);
        push_iss(cyc + 2, 32'd8, 32'd9, 6'h35);
        tick();
        dispatch(1'b0, 32'd0, 6'h3A, 1'b1, 32'd1, 6'h00, 6'h36); tick();
        dispatch(1'b0, 32'd0, 6'h3A, 1'b1, 32'd2, 6'h00, 6'h37); tick();
        reset = 1'b0;
        #1;
        check_zero_outputs("midrst");
        exp_iss.delete();
        exp_done.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        cdb(6'h3A, 32'd5);
        tick();
        repeat (L + 4) tick();

        chk("sb_iss_empty", 32'(exp_iss.size()), 0);
        chk("sb_done_empty", 32'(exp_done.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
